// File: rtl/mine_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mine_mem_arbiter_if
// Description : Bundle of requester, clear-sweep and memory-side signals
//               shared between the mine memory arbiter and its surroundings.
// Revision    : 1.0 - initial release
// ============================================================================
interface mine_mem_arbiter_if #(
  parameter int AW = 8
);
  // Requester side
  logic          req0, req1, req2;
  logic          we0, we1, we2;
  logic [AW-1:0] addr0, addr1, addr2;
  logic          wdata0, wdata1, wdata2;
  logic          gnt0, gnt1, gnt2;
  logic          rvalid0, rvalid1, rvalid2;
  logic          rdata0, rdata1, rdata2;
  // Clear sweep control
  logic          clear_start;
  logic          clear_done;
  logic          busy;
  // Memory side
  logic [AW-1:0] mem_addr;
  logic          mem_wdata;
  logic          mem_wren;
  logic          mem_q;

  // Surrounding system: requesters plus the memory itself
  modport master (
    output req0, req1, req2, we0, we1, we2, addr0, addr1, addr2,
           wdata0, wdata1, wdata2, clear_start, mem_q,
    input  gnt0, gnt1, gnt2, rvalid0, rvalid1, rvalid2,
           rdata0, rdata1, rdata2, clear_done, busy,
           mem_addr, mem_wdata, mem_wren
  );

  // Arbiter side
  modport slave (
    input  req0, req1, req2, we0, we1, we2, addr0, addr1, addr2,
           wdata0, wdata1, wdata2, clear_start, mem_q,
    output gnt0, gnt1, gnt2, rvalid0, rvalid1, rvalid2,
           rdata0, rdata1, rdata2, clear_done, busy,
           mem_addr, mem_wdata, mem_wren
  );
endinterface
`default_nettype wire

// File: rtl/mine_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mine_mem_arbiter
// Description : Round-robin arbiter for the single-port mine memory with a
//               built-in whole-board clear sweep and tagged read return.
// Revision    : 1.0 - initial release
// ============================================================================
module mine_mem_arbiter #(
  parameter int AW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  mine_mem_arbiter_if.slave    bus
);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            r_state;
  logic [1:0]        r_ptr;
  logic [AW-1:0]     r_cnt;
  logic [AW-1:0]     r_mem_addr;
  logic              r_mem_wdata;
  logic              r_mem_wren;
  logic              r_busy;
  logic              r_clear_done;
  logic [2:0]        r_rvalid;
  logic [2:0]        r_rdata;
  logic [RD_LAT:0]   r_pv;
  logic [RD_LAT:0][1:0] r_pid;

  logic [2:0]        w_req;
  logic [2:0]        w_gnt;
  logic [1:0]        w_win;
  logic [1:0]        w_cand;
  logic              w_any;
  logic              w_arb_open;
  logic              w_sel_we;
  logic              w_sel_wdata;
  logic [AW-1:0]     w_sel_addr;
  logic              w_push;

  assign w_req = {bus.req2, bus.req1, bus.req0};

  // Grants are only possible in normal arbitration, out of reset, and not in
  // the cycle that launches a sweep.
  assign w_arb_open = rst && (r_state == ST_ARB) && !bus.clear_start;

  // Round-robin search starting one past the last winner.
  always_comb begin
    w_any  = 1'b0;
    w_win  = 2'd0;
    w_cand = 2'd0;
    if (w_arb_open) begin
      for (int k = 0; k < 3; k++) begin
        w_cand = 2'((int'(r_ptr) + 1 + k) % 3);
        if (!w_any && w_req[w_cand]) begin
          w_any = 1'b1;
          w_win = w_cand;
        end
      end
    end
  end

  assign w_gnt = w_any ? (3'b001 << w_win) : 3'b000;

  // Select the winning port's transaction fields.
  always_comb begin
    w_sel_we    = bus.we0;
    w_sel_wdata = bus.wdata0;
    w_sel_addr  = bus.addr0;
    case (w_win)
      2'd1: begin
        w_sel_we    = bus.we1;
        w_sel_wdata = bus.wdata1;
        w_sel_addr  = bus.addr1;
      end
      2'd2: begin
        w_sel_we    = bus.we2;
        w_sel_wdata = bus.wdata2;
        w_sel_addr  = bus.addr2;
      end
      default: ;
    endcase
  end

  assign w_push = w_any && !w_sel_we;

  // Arbitration / clear-sweep state machine driving the memory port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_ARB;
      r_ptr        <= 2'd2;
      r_cnt        <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 1'b0;
      r_mem_wren   <= 1'b0;
      r_busy       <= 1'b0;
      r_clear_done <= 1'b0;
    end else begin
      case (r_state)
        ST_ARB: begin
          r_clear_done <= 1'b0;
          if (bus.clear_start) begin
            // First sweep write (address 0) goes out next cycle; the counter
            // already points at the following address.
            r_state     <= ST_CLEAR;
            r_busy      <= 1'b1;
            r_mem_addr  <= '0;
            r_mem_wdata <= 1'b0;
            r_mem_wren  <= 1'b1;
            r_cnt       <= AW'(1);
          end else if (w_any) begin
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_wren  <= w_sel_we;
            r_ptr       <= w_win;
          end else begin
            r_mem_wren  <= 1'b0;
          end
        end
        ST_CLEAR: begin
          // Counter wrapped to 0: the last address is being written now.
          if (r_cnt == '0) begin
            r_state      <= ST_ARB;
            r_busy       <= 1'b0;
            r_mem_wren   <= 1'b0;
            r_clear_done <= 1'b1;
          end else begin
            r_mem_addr <= r_cnt;
            r_cnt      <= r_cnt + AW'(1);
          end
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end

  // Read tag delay line and data return, independent of the sweep state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pv     <= '0;
      r_pid    <= '0;
      r_rvalid <= 3'b000;
      r_rdata  <= 3'b000;
    end else begin
      r_pv     <= {r_pv[RD_LAT-1:0], w_push};
      r_pid    <= {r_pid[RD_LAT-1:0], w_win};
      r_rvalid <= 3'b000;
      if (r_pv[RD_LAT]) begin
        r_rvalid[r_pid[RD_LAT]] <= 1'b1;
        r_rdata[r_pid[RD_LAT]]  <= bus.mem_q;
      end
    end
  end

  assign bus.gnt0       = w_gnt[0];
  assign bus.gnt1       = w_gnt[1];
  assign bus.gnt2       = w_gnt[2];
  assign bus.rvalid0    = r_rvalid[0];
  assign bus.rvalid1    = r_rvalid[1];
  assign bus.rvalid2    = r_rvalid[2];
  assign bus.rdata0     = r_rdata[0];
  assign bus.rdata1     = r_rdata[1];
  assign bus.rdata2     = r_rdata[2];
  assign bus.clear_done = r_clear_done;
  assign bus.busy       = r_busy;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.mem_wren   = r_mem_wren;

endmodule
`default_nettype wire

// File: doc/mine_mem_arbiter.md
# mine_mem_arbiter

Arbiter and sequencer for the single-port 256x1 mine memory, addressed as {y[3:0], x[3:0]}. It shares the memory between three requesters: the mine placer (port 0), the reveal/count logic (port 1) and the display scanner (port 2). It also runs a built-in clear sweep that zeroes the whole board before placement. It owns the memory's address, data and write-enable lines and routes read data back to the port that issued the read.

## Interface
Parameters:
- AW, 8: memory address width. Depth is 2^AW.
- RD_LAT, 1: number of clock edges between mem_addr becoming valid and mem_q becoming valid. Legal range 1..3.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- req0, req1, req2  input  1 each  transaction request. Held high with we/addr/wdata stable until the matching gnt is seen.
- we0, we1, we2  input  1 each  1 = write, 0 = read
- addr0, addr1, addr2  input  AW each  target address
- wdata0, wdata1, wdata2  input  1 each  write data
- gnt0, gnt1, gnt2  output  1 each  combinational, one-hot. Request accepted this cycle.
- rvalid0, rvalid1, rvalid2  output  1 each  registered one-cycle read-data strobe
- rdata0, rdata1, rdata2  output  1 each  registered read data, valid while the matching rvalid is high
- clear_start  input  1  pulse that begins the clear sweep
- clear_done  output  1  registered one-cycle pulse when the sweep finishes
- busy  output  1  registered, high during the sweep
- mem_addr  output  AW  registered memory address
- mem_wdata  output  1  registered memory write data
- mem_wren  output  1  registered memory write enable
- mem_q  input  1  memory read data

## Operation
- States:
  - ARB: normal arbitration.
  - CLEAR: sweep in progress.
- Reset: state ARB; last-grant pointer = 2, so the first search starts at port 0. Reset value of every registered output is 0: mem_addr, mem_wdata, mem_wren, rvalid*, rdata*, clear_done, busy. Sweep counter = 0. Read pipeline is flushed.
- ARB, clear_start low:
  - Round-robin search starting at (pointer+1) mod 3.
  - The first port found with req high gets gnt. At most one gnt per cycle.
  - On the grant edge: mem_addr/mem_wdata/mem_wren are loaded from the winning port, and the pointer is set to the winner.
- ARB with no grant: mem_wren = 0. mem_addr and mem_wdata hold their values.
- ARB, clear_start high: enter CLEAR. No gnt that cycle, even if requests are pending.
- CLEAR:
  - All gnt are low. mem_wren = 1, mem_wdata = 0, mem_addr = counter.
  - The counter runs 0..2^AW-1, one address per cycle.
  - After the write of address 2^AW-1: return to ARB, pulse clear_done, drop busy, reset the counter to 0.
  - clear_start is ignored while in CLEAR.
  - The pointer is unchanged by the sweep.
- Read return:
  - Each granted read pushes {valid, port id} into a delay line of depth RD_LAT+1.
  - At the delay-line output, mem_q is captured into the rdata of the tagged port and its rvalid pulses.
  - Other ports' rdata hold their values.
- Reads granted before a CLEAR still complete, because the delay line runs independently of state.
- Writes produce no rvalid.
- Requester rules: a gnt is accepted only while req is high. A port that drops req before its gnt has no transaction issued.
- Asynchronous reset mid-sweep or mid-read: everything returns to reset values immediately and the in-flight read is discarded. No writes occur until a new grant or a new clear_start.

## Timing
- Grant in cycle T: mem_addr/mem_wren/mem_wdata are valid in T+1. mem_wren is high for exactly one cycle (T+1) for a write.
- Read granted in cycle T: mem_q is valid in T+1+RD_LAT. rvalid/rdata are valid in T+2+RD_LAT, which is T+3 at the default.
- Throughput: one transaction per cycle. Back-to-back reads from different ports return in grant order, one per cycle.
- clear_start high in cycle C:
  - busy is high in cycles C+1..C+2^AW.
  - mem_wren is high with mem_addr = 0..2^AW-1 over those same cycles.
  - clear_done is high in cycle C+2^AW+1, which is also the first cycle a new gnt can be issued.
- Write followed by read of the same address on consecutive grants returns the new data (memory is write-then-read in order).

## Test plan
- Reset: hold rst low with random inputs → all registered outputs 0 and all gnt 0. After release, req1 alone → gnt1 in the same cycle.
- Single read: port 2 reads 0x37 with model memory[0x37] = 1, granted in T → mem_addr = 0x37 and mem_wren = 0 in T+1; rvalid2 = 1 and rdata2 = 1 in T+3; rvalid0 and rvalid1 stay 0.
- Fairness: req0, req1, req2 held high for 6 cycles (each re-requesting after its gnt) → grant sequence 0, 1, 2, 0, 1, 2, with exactly one gnt per cycle.
- Write: port 0 writes 0xFF with wdata 1 → mem_wren = 1, mem_addr = 0xFF, mem_wdata = 1 in T+1 only; no rvalid. Then port 1 reads 0xFF → rdata1 = 1.
- Clear: clear_start with req1 pending and a port-2 read granted the previous cycle → port-2 rvalid still arrives; gnt1 stays low for 256 cycles while mem_addr runs 0x00..0xFF with wren = 1 and wdata = 0; clear_done pulses once; gnt1 is high in the same cycle.
- Reset mid-sweep: assert rst at mem_addr = 0x80 → mem_wren, busy and clear_done go 0 immediately. After release, no mem_wren for 300 idle cycles.
